collision_detect: RTL and testbench
===================================

Name: collision_detect

Overview:
- Per-pixel collision accumulator sitting directly downstream of the sprite draw units, in parallel with the drawing priority mux.
- During each frame it consumes the raw per-sprite draw flags (ship, torpedoes, asteroids) and latches every pairwise overlap.
- At frame boundary it emits one-cycle hit pulses to the ship/torpedo/asteroid units and lives counter.
- It then serialises score-add pulses (amount per asteroid size) toward score_box.

Parameters:
- T_NUM, 4, number of torpedo instances.
- A_NUM, 8, number of asteroid instances.
- PTS_LARGE, 20, points for a large asteroid (size code 0).
- PTS_MEDIUM, 50, points for a medium asteroid (size code 1).
- PTS_SMALL, 100, points for a small asteroid (size code 2).
- SUM_W, 8, width of score_sum.

Ports:
- clk  in  1  pixel clock (25 MHz domain)
- resetN  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse on vsync rising edge
- enable  in  1  0 = accumulation gated off (game over / attract)
- draw_ship  in  1  ship sprite opaque at current pixel
- draw_torpedo  in  T_NUM  per-torpedo opaque flag
- draw_asteroid  in  A_NUM  per-asteroid opaque flag
- asteroid_size  in  A_NUM x 2  size code per asteroid, sampled at frame_start
- ship_hit  out  1  one-cycle pulse: ship overlapped any asteroid last frame
- torpedo_hit  out  T_NUM  one-cycle pulses: torpedo t hit an asteroid (retire it)
- asteroid_hit  out  A_NUM  one-cycle pulses: asteroid a hit by torpedo or ship (split/destroy)
- score_add  out  1  one-cycle pulse, add score_sum to score
- score_sum  out  SUM_W  points for current score_add
- busy  out  1  report sequence in progress

Behaviour:
- Reset (async, resetN=0): all accumulators, snapshot registers and outputs = 0; FSM = ACCUM.
- Accumulation (every cycle, enable=1):
  - ship_acc |= draw_ship & |draw_asteroid.
  - For each t, a: tor_acc[t] |= draw_torpedo[t] & draw_asteroid[a], and tor_ast_acc[a] |= the same term.
  - ast_acc[a] |= draw_asteroid[a] & (draw_ship | |draw_torpedo).
  - enable=0: no accumulation; existing accumulator bits hold.
- frame_start at cycle N:
  - Copy accumulators to snapshot registers; copy asteroid_size into size snapshot.
  - Clear accumulators. Overlaps present in cycle N itself are accumulated into the NEW frame (clear, then OR the cycle-N terms).
- Cycle N+1:
  - ship_hit = ship snapshot; torpedo_hit = tor snapshot; asteroid_hit = ast snapshot.
  - All of these are exactly one cycle wide and 0 otherwise.
- FSM states:
  - ACCUM: idle reporting, busy=0.
  - REPORT: index i walks 0..A_NUM-1, one index per cycle starting at N+1, busy=1.
  - In REPORT, if tor_ast snapshot[i]=1 and size[i]!=3: score_add=1, score_sum=points(size[i]).
  - Otherwise score_add=0 and score_sum=0.
  - Size code 3 is reserved: no pulse.
  - Ship-only asteroid hits score nothing.
  - After i=A_NUM-1, return to ACCUM (busy falls at cycle N+1+A_NUM).
  - Transition ACCUM->REPORT on frame_start, only if any tor_ast accumulator bit is set at that cycle; otherwise stay in ACCUM. Hit pulses are still emitted at N+1 either way.
- Score pulse timing: score pulses occur at N+1+i for each scoring asteroid i. Maximum report length is A_NUM cycles.
- Simultaneous events:
  - frame_start while in REPORT: abort the remaining indices (their points are lost), snapshot the new frame, restart at i=0.
  - Multiple torpedoes hitting one asteroid: a single score pulse; every involved torpedo gets torpedo_hit.
  - One torpedo hitting several asteroids: all those asteroids get asteroid_hit and score.
- Width rules:
  - points() is zero-extended to SUM_W.
  - Parameters exceeding 2^SUM_W-1 are a configuration error; flag with an elaboration-time assertion.
- Mid-operation reset: immediate return to reset state; no pulses are emitted after deassertion until the next frame_start.

Decomposition:
- Shared game package holds:
  - the size-code enum (SIZE_LARGE=0, SIZE_MEDIUM=1, SIZE_SMALL=2, SIZE_NONE=3);
  - T_NUM and A_NUM defaults;
  - point constants, shared with the asteroid unit and score_box.
- One sub-module, collision_score_seq: the REPORT FSM, index counter and points lookup.
- The top of collision_detect holds the accumulator/snapshot logic.

Test Plan:
- Torpedo 1 overlaps asteroid 2 (size 1) for 3 pixels in frame k, then frame_start at cycle N:
  - torpedo_hit=4'b0010 and asteroid_hit=8'h04 at N+1;
  - score_add with score_sum=50 at N+3;
  - busy high N+1..N+8.
- Ship overlaps asteroid 0, no torpedo overlap:
  - ship_hit=1 and asteroid_hit=8'h01 at N+1;
  - no score_add, busy stays 0.
- Torpedoes 0 and 3 both hit asteroid 5 (size 2), torpedo 0 also hits asteroid 7 (size 3):
  - torpedo_hit=4'b1001 and asteroid_hit=8'hA0 at N+1;
  - single score_add of 100 at N+6;
  - no pulse at N+8.
- Overlap present only in the frame_start cycle:
  - no pulses at N+1;
  - corresponding pulses at the following frame_start+1.
- Second frame_start injected 3 cycles after the first, with asteroids 1 and 6 pending:
  - the asteroid 6 score is dropped;
  - the new snapshot reports from i=0.
- enable=0 with overlaps present, then resetN pulsed low mid-REPORT:
  - no hit pulses;
  - all outputs 0 immediately on reset assertion, and remain 0 until the next frame_start.

Source files
------------

// File: rtl/collision_detect_pkg.sv
// Shared game constants and types for the collision / scoring path.
// Point values are also used by the asteroid unit and score_box.
package collision_detect_pkg;

    localparam int T_NUM_DEF      = 4;
    localparam int A_NUM_DEF      = 8;
    localparam int PTS_LARGE_DEF  = 20;
    localparam int PTS_MEDIUM_DEF = 50;
    localparam int PTS_SMALL_DEF  = 100;
    localparam int SUM_W_DEF      = 8;

    typedef enum logic [1:0] {
        SIZE_LARGE  = 2'd0,
        SIZE_MEDIUM = 2'd1,
        SIZE_SMALL  = 2'd2,
        SIZE_NONE   = 2'd3
    } size_e;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } rep_state_e;

endpackage

// File: rtl/collision_detect_if.sv
// Draw-flag inputs and hit/score outputs of the collision accumulator.
interface collision_detect_if
    import collision_detect_pkg::*;
#(
    parameter int T_NUM = T_NUM_DEF,
    parameter int A_NUM = A_NUM_DEF,
    parameter int SUM_W = SUM_W_DEF
);
    logic                  frame_start;
    logic                  enable;
    logic                  draw_ship;
    logic [T_NUM-1:0]      draw_torpedo;
    logic [A_NUM-1:0]      draw_asteroid;
    logic [A_NUM-1:0][1:0] asteroid_size;
    logic                  ship_hit;
    logic [T_NUM-1:0]      torpedo_hit;
    logic [A_NUM-1:0]      asteroid_hit;
    logic                  score_add;
    logic [SUM_W-1:0]      score_sum;
    logic                  busy;

    modport master (
        output frame_start, enable, draw_ship, draw_torpedo,
        output draw_asteroid, asteroid_size,
        input  ship_hit, torpedo_hit, asteroid_hit,
        input  score_add, score_sum, busy
    );

    modport slave (
        input  frame_start, enable, draw_ship, draw_torpedo,
        input  draw_asteroid, asteroid_size,
        output ship_hit, torpedo_hit, asteroid_hit,
        output score_add, score_sum, busy
    );
endinterface

// File: rtl/collision_detect_score_seq.sv
// Walks the torpedo-hit snapshot one asteroid per cycle and
// emits a score pulse with the size-dependent point value.
module collision_score_seq
    import collision_detect_pkg::*;
#(
    parameter int A_NUM      = A_NUM_DEF,
    parameter int PTS_LARGE  = PTS_LARGE_DEF,
    parameter int PTS_MEDIUM = PTS_MEDIUM_DEF,
    parameter int PTS_SMALL  = PTS_SMALL_DEF,
    parameter int SUM_W      = SUM_W_DEF
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  start,
    input  logic                  any_hit,
    input  logic [A_NUM-1:0]      tor_ast_snap,
    input  logic [A_NUM-1:0][1:0] size_snap,
    output logic                  score_add,
    output logic [SUM_W-1:0]      score_sum,
    output logic                  busy
);
    localparam int IDX_W = (A_NUM > 1) ? $clog2(A_NUM) : 1;

    rep_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    size_e            cur_size;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        score_add = 1'b0;
        score_sum = '0;
        busy      = (state_q == ST_REPORT);
        cur_size  = size_e'(size_snap[idx_q]);
        if (state_q == ST_REPORT) begin
            if (tor_ast_snap[idx_q] && cur_size != SIZE_NONE) begin
                score_add = 1'b1;
                unique case (cur_size)
                    SIZE_LARGE:  score_sum = SUM_W'(PTS_LARGE);
                    SIZE_MEDIUM: score_sum = SUM_W'(PTS_MEDIUM);
                    SIZE_SMALL:  score_sum = SUM_W'(PTS_SMALL);
                    default:     score_sum = '0;
                endcase
            end
            if (idx_q == IDX_W'(A_NUM - 1)) begin
                state_d = ST_ACCUM;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        // a new frame aborts whatever is left of the current walk
        if (start) begin
            state_d = any_hit ? ST_REPORT : ST_ACCUM;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_ACCUM;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: rtl/collision_detect.sv
// Per-pixel collision accumulator: latches sprite overlaps over a
// frame, pulses hits at frame start, then serialises score adds.
module collision_detect
    import collision_detect_pkg::*;
#(
    parameter int T_NUM      = T_NUM_DEF,
    parameter int A_NUM      = A_NUM_DEF,
    parameter int PTS_LARGE  = PTS_LARGE_DEF,
    parameter int PTS_MEDIUM = PTS_MEDIUM_DEF,
    parameter int PTS_SMALL  = PTS_SMALL_DEF,
    parameter int SUM_W      = SUM_W_DEF
) (
    input logic               clk,
    input logic               resetN,
    collision_detect_if.slave bus
);
    if (((PTS_LARGE >> SUM_W) != 0) || ((PTS_MEDIUM >> SUM_W) != 0) ||
        ((PTS_SMALL >> SUM_W) != 0)) begin : g_pts_chk
        $error("collision_detect: point value does not fit score_sum");
    end

    logic                  ship_term;
    logic [T_NUM-1:0]      tor_term;
    logic [A_NUM-1:0]      ast_term, tor_ast_term;
    logic                  ship_acc_q, ship_acc_d;
    logic [T_NUM-1:0]      tor_acc_q, tor_acc_d;
    logic [A_NUM-1:0]      ast_acc_q, ast_acc_d;
    logic [A_NUM-1:0]      tor_ast_acc_q, tor_ast_acc_d;
    logic                  ship_hit_q, ship_hit_d;
    logic [T_NUM-1:0]      tor_hit_q, tor_hit_d;
    logic [A_NUM-1:0]      ast_hit_q, ast_hit_d;
    logic [A_NUM-1:0]      tor_ast_snap_q, tor_ast_snap_d;
    logic [A_NUM-1:0][1:0] size_snap_q, size_snap_d;

    always_comb begin
        ship_term    = bus.draw_ship & (|bus.draw_asteroid);
        tor_term     = bus.draw_torpedo & {T_NUM{|bus.draw_asteroid}};
        tor_ast_term = bus.draw_asteroid & {A_NUM{|bus.draw_torpedo}};
        ast_term     = bus.draw_asteroid &
                       {A_NUM{bus.draw_ship | (|bus.draw_torpedo)}};
        if (!bus.enable) begin
            ship_term    = 1'b0;
            tor_term     = '0;
            tor_ast_term = '0;
            ast_term     = '0;
        end
    end

    always_comb begin
        ship_acc_d     = ship_acc_q | ship_term;
        tor_acc_d      = tor_acc_q | tor_term;
        ast_acc_d      = ast_acc_q | ast_term;
        tor_ast_acc_d  = tor_ast_acc_q | tor_ast_term;
        ship_hit_d     = 1'b0;
        tor_hit_d      = '0;
        ast_hit_d      = '0;
        tor_ast_snap_d = tor_ast_snap_q;
        size_snap_d    = size_snap_q;
        // frame-start overlaps belong to the new frame
        if (bus.frame_start) begin
            ship_acc_d     = ship_term;
            tor_acc_d      = tor_term;
            ast_acc_d      = ast_term;
            tor_ast_acc_d  = tor_ast_term;
            ship_hit_d     = ship_acc_q;
            tor_hit_d      = tor_acc_q;
            ast_hit_d      = ast_acc_q;
            tor_ast_snap_d = tor_ast_acc_q;
            size_snap_d    = bus.asteroid_size;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ship_acc_q     <= 1'b0;
            tor_acc_q      <= '0;
            ast_acc_q      <= '0;
            tor_ast_acc_q  <= '0;
            ship_hit_q     <= 1'b0;
            tor_hit_q      <= '0;
            ast_hit_q      <= '0;
            tor_ast_snap_q <= '0;
            size_snap_q    <= '0;
        end else begin
            ship_acc_q     <= ship_acc_d;
            tor_acc_q      <= tor_acc_d;
            ast_acc_q      <= ast_acc_d;
            tor_ast_acc_q  <= tor_ast_acc_d;
            ship_hit_q     <= ship_hit_d;
            tor_hit_q      <= tor_hit_d;
            ast_hit_q      <= ast_hit_d;
            tor_ast_snap_q <= tor_ast_snap_d;
            size_snap_q    <= size_snap_d;
        end
    end

    assign bus.ship_hit     = ship_hit_q;
    assign bus.torpedo_hit  = tor_hit_q;
    assign bus.asteroid_hit = ast_hit_q;

    collision_score_seq #(
        .A_NUM      (A_NUM),
        .PTS_LARGE  (PTS_LARGE),
        .PTS_MEDIUM (PTS_MEDIUM),
        .PTS_SMALL  (PTS_SMALL),
        .SUM_W      (SUM_W)
    ) u_score_seq (
        .clk          (clk),
        .resetN       (resetN),
        .start        (bus.frame_start),
        .any_hit      (|tor_ast_acc_q),
        .tor_ast_snap (tor_ast_snap_q),
        .size_snap    (size_snap_q),
        .score_add    (bus.score_add),
        .score_sum    (bus.score_sum),
        .busy         (bus.busy)
    );
endmodule

// File: tb/tb_collision_detect.sv
// Directed and random checks of collision_detect against a
// frame-level overlap model with a queue of expected report cycles.
module tb_collision_detect;
    import collision_detect_pkg::*;

    localparam int T = 4;
    localparam int A = 8;

    typedef struct packed {
        logic       busy;
        logic       add;
        logic [7:0] sum;
    } rep_t;

    logic clk;
    logic resetN;
    int   n_cmp;
    int   n_bad;

    bit   pair [T][A];
    bit   shov [A];
    rep_t rq [$];

    collision_detect_if bus ();

    collision_detect dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pts(input logic [1:0] s);
        case (s)
            2'd0:    return 8'd20;
            2'd1:    return 8'd50;
            2'd2:    return 8'd100;
            default: return 8'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ship"}, 32'(bus.ship_hit), 0);
        chk({tag, "_tor"},  32'(bus.torpedo_hit), 0);
        chk({tag, "_ast"},  32'(bus.asteroid_hit), 0);
        chk({tag, "_add"},  32'(bus.score_add), 0);
        chk({tag, "_sum"},  32'(bus.score_sum), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    task automatic clear_model();
        for (int t = 0; t < T; t++)
            for (int a = 0; a < A; a++) pair[t][a] = 1'b0;
        for (int a = 0; a < A; a++) shov[a] = 1'b0;
        rq.delete();
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // one pixel cycle: drive, update model, clock, compare
    task automatic cyc(input bit fs, input bit sh,
                       input logic [T-1:0] tr, input logic [A-1:0] as);
        logic         e_ship;
        logic [T-1:0] e_tor;
        logic [A-1:0] e_ast;
        bit           tor_on [A];
        bit           any;
        rep_t         e_rep;
        e_ship = 1'b0;
        e_tor  = '0;
        e_ast  = '0;
        any    = 1'b0;
        bus.frame_start   = fs;
        bus.draw_ship     = sh;
        bus.draw_torpedo  = tr;
        bus.draw_asteroid = as;
        if (fs) begin
            for (int a = 0; a < A; a++) begin
                tor_on[a] = 1'b0;
                for (int t = 0; t < T; t++)
                    if (pair[t][a]) begin
                        tor_on[a] = 1'b1;
                        e_tor[t]  = 1'b1;
                    end
                if (tor_on[a] || shov[a]) e_ast[a] = 1'b1;
                if (shov[a]) e_ship = 1'b1;
                if (tor_on[a]) any = 1'b1;
            end
            clear_model();
            if (any)
                for (int a = 0; a < A; a++) begin
                    e_rep.busy = 1'b1;
                    e_rep.add  = tor_on[a] && bus.asteroid_size[a] != 2'd3;
                    e_rep.sum  = e_rep.add ? pts(bus.asteroid_size[a]) : 8'd0;
                    rq.push_back(e_rep);
                end
        end
        if (bus.enable)
            for (int a = 0; a < A; a++) begin
                if (sh && as[a]) shov[a] = 1'b1;
                for (int t = 0; t < T; t++)
                    if (tr[t] && as[a]) pair[t][a] = 1'b1;
            end
        e_rep = (rq.size() > 0) ? rq.pop_front() : '0;
        step();
        chk("ship_hit", 32'(bus.ship_hit), 32'(e_ship));
        chk("torpedo_hit", 32'(bus.torpedo_hit), 32'(e_tor));
        chk("asteroid_hit", 32'(bus.asteroid_hit), 32'(e_ast));
        chk("score_add", 32'(bus.score_add), 32'(e_rep.add));
        chk("score_sum", 32'(bus.score_sum), 32'(e_rep.sum));
        chk("busy", 32'(bus.busy), 32'(e_rep.busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        resetN = 1'b0;
        bus.frame_start   = 1'b0;
        bus.enable        = 1'b1;
        bus.draw_ship     = 1'b0;
        bus.draw_torpedo  = '0;
        bus.draw_asteroid = '0;
        bus.asteroid_size = '0;
        clear_model();
        step();
        chk_idle("reset");
        step();
        resetN = 1'b1;
        idle(2);

        // torpedo 1 x asteroid 2 (medium) for 3 pixels
        bus.asteroid_size[2] = 2'd1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'b0010, 8'h04);
        idle(2);
        cyc(1'b1, 1'b0, '0, '0);
        chk("t1_tor", 32'(bus.torpedo_hit), 32'h2);
        chk("t1_ast", 32'(bus.asteroid_hit), 32'h04);
        chk("t1_busy_n1", 32'(bus.busy), 1);
        cyc(1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, '0, '0);
        chk("t1_add_n3", 32'(bus.score_add), 1);
        chk("t1_sum_n3", 32'(bus.score_sum), 50);
        idle(5);
        chk("t1_busy_n8", 32'(bus.busy), 1);
        idle(1);
        chk("t1_busy_n9", 32'(bus.busy), 0);
        idle(2);

        // ship x asteroid 0 only
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, '0, 8'h01);
        cyc(1'b1, 1'b0, '0, '0);
        chk("t2_ship", 32'(bus.ship_hit), 1);
        chk("t2_ast", 32'(bus.asteroid_hit), 32'h01);
        idle(9);

        // torpedoes 0,3 x asteroid 5 (small), torpedo 0 x asteroid 7 (none)
        bus.asteroid_size[5] = 2'd2;
        bus.asteroid_size[7] = 2'd3;
        cyc(1'b0, 1'b0, 4'b0001, 8'hA0);
        cyc(1'b0, 1'b0, 4'b1000, 8'h20);
        idle(1);
        cyc(1'b1, 1'b0, '0, '0);
        chk("t3_tor", 32'(bus.torpedo_hit), 32'h9);
        chk("t3_ast", 32'(bus.asteroid_hit), 32'hA0);
        idle(5);
        chk("t3_sum_n6", 32'(bus.score_sum), 100);
        idle(2);
        chk("t3_add_n8", 32'(bus.score_add), 0);
        idle(2);

        // overlap only in the frame_start cycle
        cyc(1'b1, 1'b0, 4'b0100, 8'h01);
        chk("t4_tor_n1", 32'(bus.torpedo_hit), 0);
        idle(9);
        cyc(1'b1, 1'b0, '0, '0);
        chk("t4_tor_next", 32'(bus.torpedo_hit), 32'h4);
        idle(10);

        // second frame_start 3 cycles in drops asteroid 6
        bus.asteroid_size[1] = 2'd0;
        bus.asteroid_size[6] = 2'd1;
        bus.asteroid_size[3] = 2'd2;
        cyc(1'b0, 1'b0, 4'b0100, 8'h42);
        cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, 4'b0001, 8'h08);
        chk("t5_add_i1", 32'(bus.score_sum), 20);
        idle(1);
        cyc(1'b1, 1'b0, '0, '0);
        idle(10);

        // gated accumulation, then reset mid-report
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b0011, 8'h03);
        cyc(1'b1, 1'b0, '0, '0);
        chk("t6_gated_ast", 32'(bus.asteroid_hit), 0);
        bus.enable = 1'b1;
        idle(2);
        cyc(1'b0, 1'b0, 4'b0001, 8'h01);
        cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, '0, '0);
        #2;
        resetN = 1'b0;
        #1;
        chk_idle("t6_async");
        bus.draw_torpedo  = 4'b0001;
        bus.draw_asteroid = 8'h01;
        step();
        chk_idle("t6_hold");
        resetN = 1'b1;
        clear_model();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'b0010, 8'h02);
        cyc(1'b1, 1'b0, '0, '0);
        idle(9);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            bit           fs;
            logic [T-1:0] tr;
            logic [A-1:0] as;
            fs = ($urandom_range(0, 19) == 0);
            bus.enable = ($urandom_range(0, 9) != 0);
            if (fs && $urandom_range(0, 1) == 1)
                bus.asteroid_size = 16'($urandom);
            tr = 4'($urandom) & 4'($urandom);
            as = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cyc(fs, ($urandom_range(0, 5) == 0), tr, as);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
